dm_arbiter: RTL and testbench

- Shares the single write/read port of the data memory between the CPU MEM stage and the debug/loader unit (PDU).
- Requests use a valid/ready handshake. A read returns one cycle after grant.
- CPU has fixed priority, bounded by a starvation counter. The debug side may lock the port for bursts, such as a program load.
- Sits between the CPU core and Data_mem. It drives Data_mem's dm_we/dm_addr/dm_din and consumes dm_dout, which is an asynchronous read.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_arb_rsp.sv | 30 +++
 rtl/dm_arbiter.sv | 155 +++++++++++++++
 tb/tb_dm_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU MEM stage and the debug unit.
// Holds the state encoding, the requester IDs and the default starvation limit.
package dm_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_CPU  = 2'd1,
      REQ_DBG  = 2'd2
   } req_id_t;

   localparam int DM_ARB_MAX_WAIT = 4;
   localparam int DM_ARB_CNT_W    = 3;

endpackage

// File: rtl/dm_arb_rsp.sv
// Per-requester read response: captures the memory data on a read-grant edge and pulses rvalid for one cycle.
// Latency 1 cycle from the grant; there is no backpressure, and rdata holds until the next read completes.
module dm_arb_rsp (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rd_fire,
   input  logic [31:0] i_dout,
   output logic        o_rvalid,
   output logic [31:0] o_rdata
);

   logic        r_rvalid;
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= i_rd_fire;
         if (i_rd_fire) begin
            r_rdata <= i_dout;
         end
      end
   end

   assign o_rvalid = r_rvalid;
   assign o_rdata  = r_rdata;

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the Data_mem port between the CPU (fixed priority, starvation-bounded) and the debug unit (lockable); grant is combinational and reads return 1 cycle later.
// A requester that is not granted stalls, and holds its request. DM_ARB_PERF_EN adds the conflict and force performance counters.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int MAX_WAIT = DM_ARB_MAX_WAIT,
   parameter int CNT_W    = DM_ARB_CNT_W
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cpu_req,
   input  logic        i_cpu_we,
   input  logic [31:0] i_cpu_addr,
   input  logic [31:0] i_cpu_wdata,
   output logic        o_cpu_gnt,
   output logic        o_cpu_rvalid,
   output logic [31:0] o_cpu_rdata,
   input  logic        i_dbg_req,
   input  logic        i_dbg_we,
   input  logic [31:0] i_dbg_addr,
   input  logic [31:0] i_dbg_wdata,
   input  logic        i_dbg_lock,
   output logic        o_dbg_gnt,
   output logic        o_dbg_rvalid,
   output logic [31:0] o_dbg_rdata,
   output logic        o_dbg_locked,
`ifdef DM_ARB_PERF_EN
   output logic [31:0] o_perf_conflict,
   output logic [31:0] o_perf_force,
`endif
   output logic        o_dm_we,
   output logic [31:0] o_dm_addr,
   output logic [31:0] o_dm_din,
   input  logic [31:0] i_dm_dout
);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   req_id_t          w_sel;
   logic             w_force;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ARB;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel       = REQ_NONE;
      w_force     = 1'b0;
      case (r_state)
         ARB: begin
            w_force = i_dbg_req && (r_wait_cnt == CNT_W'(MAX_WAIT));
            if (w_force) begin
               w_sel = REQ_DBG;
            end else if (i_cpu_req) begin
               w_sel = REQ_CPU;
            end else if (i_dbg_req) begin
               w_sel = REQ_DBG;
            end
            // Locking must never cut off a CPU access already granted this cycle.
            if (i_dbg_lock && (w_sel != REQ_CPU)) begin
               w_state_nxt = LOCK;
            end
         end
         LOCK: begin
            if (i_dbg_req) begin
               w_sel = REQ_DBG;
            end
            if (!i_dbg_lock) begin
               w_state_nxt = ARB;
            end
         end
         default: w_state_nxt = ARB;
      endcase
   end

   assign o_cpu_gnt    = (w_sel == REQ_CPU);
   assign o_dbg_gnt    = (w_sel == REQ_DBG);
   assign o_dbg_locked = (r_state == LOCK);

   always_comb begin
      w_wait_nxt = '0;
      if ((r_state == ARB) && i_dbg_req && !o_dbg_gnt) begin
         w_wait_nxt = (r_wait_cnt == CNT_W'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      o_dm_we   = 1'b0;
      o_dm_addr = '0;
      o_dm_din  = '0;
      case (w_sel)
         REQ_CPU: begin
            o_dm_we   = i_cpu_we;
            o_dm_addr = i_cpu_addr;
            o_dm_din  = i_cpu_wdata;
         end
         REQ_DBG: begin
            o_dm_we   = i_dbg_we;
            o_dm_addr = i_dbg_addr;
            o_dm_din  = i_dbg_wdata;
         end
         default: ;
      endcase
   end

   dm_arb_rsp u_cpu_rsp (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_rd_fire (o_cpu_gnt && !i_cpu_we),
      .i_dout    (i_dm_dout),
      .o_rvalid  (o_cpu_rvalid),
      .o_rdata   (o_cpu_rdata)
   );

   dm_arb_rsp u_dbg_rsp (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_rd_fire (o_dbg_gnt && !i_dbg_we),
      .i_dout    (i_dm_dout),
      .o_rvalid  (o_dbg_rvalid),
      .o_rdata   (o_dbg_rdata)
   );

`ifdef DM_ARB_PERF_EN
   logic [31:0] r_perf_conflict;
   logic [31:0] r_perf_force;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_conflict <= '0;
         r_perf_force    <= '0;
      end else begin
         if (i_cpu_req && i_dbg_req && (r_perf_conflict != '1)) begin
            r_perf_conflict <= r_perf_conflict + 32'd1;
         end
         if (w_force && (r_perf_force != '1)) begin
            r_perf_force <= r_perf_force + 32'd1;
         end
      end
   end

   assign o_perf_conflict = r_perf_conflict;
   assign o_perf_force    = r_perf_force;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized plus directed bench for dm_arbiter, compared cycle by cycle against a behavioural model of the grant rules.
// The bench keeps its own Data_mem array, and the model keeps an independent copy of the expected memory contents.
module tb_dm_arbiter;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, dbg_locked;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic        dm_we;
   logic [31:0] dm_addr, dm_din, dm_dout;
`ifdef DM_ARB_PERF_EN
   logic [31:0] perf_conflict, perf_force;
`endif

   logic [31:0] mem [256];
   assign dm_dout = mem[dm_addr[9:2]];
   always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_din;

   always #5 clk = ~clk;

   dm_arbiter #(.MAX_WAIT(MAXW), .CNT_W(3)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
      .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
      .i_dbg_lock(dbg_lock), .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid),
      .o_dbg_rdata(dbg_rdata), .o_dbg_locked(dbg_locked),
`ifdef DM_ARB_PERF_EN
      .o_perf_conflict(perf_conflict), .o_perf_force(perf_force),
`endif
      .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_din(dm_din), .i_dm_dout(dm_dout)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // Reference model state
   bit [31:0] m_mem [256];
   bit        m_locked;
   int        m_starve;
   bit        m_crv, m_drv;
   bit [31:0] m_crd, m_drd;
   longint    m_conf, m_forced;

   // One clock cycle with the currently assigned inputs; checks comb outputs, then registered ones.
   task automatic step(input bit r);
      bit egc, egd, frc, ewe;
      bit [31:0] ea, ed;
      @(negedge clk);
      rst = r;
      if (r) begin
         cpu_req = 1'b0;
         dbg_req = 1'b0;
      end
      #1;
      egc = 0; egd = 0; frc = 0;
      if (m_locked) begin
         egd = dbg_req;
      end else if (dbg_req && m_starve >= MAXW) begin
         egd = 1; frc = 1;
      end else if (cpu_req) begin
         egc = 1;
      end else if (dbg_req) begin
         egd = 1;
      end
      ewe = egc ? cpu_we : egd ? dbg_we : 1'b0;
      ea  = egc ? cpu_addr : egd ? dbg_addr : 32'd0;
      ed  = egc ? cpu_wdata : egd ? dbg_wdata : 32'd0;
      check("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, egc});
      check("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, egd});
      check("dm_we", {31'd0, dm_we}, {31'd0, ewe});
      check("dm_addr", dm_addr, ea);
      check("dm_din", dm_din, ed);
      if (r) begin
         m_locked = 0; m_starve = 0; m_crv = 0; m_drv = 0; m_crd = 0; m_drd = 0;
         m_conf = 0; m_forced = 0;
      end else begin
         m_crv = egc && !cpu_we;
         m_drv = egd && !dbg_we;
         if (m_crv) m_crd = m_mem[cpu_addr[9:2]];
         if (m_drv) m_drd = m_mem[dbg_addr[9:2]];
         if (ewe) m_mem[ea[9:2]] = ed;
         if (!m_locked && dbg_req && !egd) m_starve = (m_starve + 1 > MAXW) ? MAXW : m_starve + 1;
         else m_starve = 0;
         m_locked = m_locked ? dbg_lock : (dbg_lock && !egc);
         if (cpu_req && dbg_req && m_conf < 64'hFFFF_FFFF) m_conf++;
         if (frc && m_forced < 64'hFFFF_FFFF) m_forced++;
      end
      @(posedge clk);
      #1;
      check("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, m_crv});
      check("cpu_rdata", cpu_rdata, m_crd);
      check("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, m_drv});
      check("dbg_rdata", dbg_rdata, m_drd);
      check("dbg_locked", {31'd0, dbg_locked}, {31'd0, m_locked});
`ifdef DM_ARB_PERF_EN
      check("perf_conflict", perf_conflict, m_conf[31:0]);
      check("perf_force", perf_force, m_forced[31:0]);
`endif
   endtask

   task automatic set_cpu(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d);
      cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dbg(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d, input bit lk);
      dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_lock = lk;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]   = 32'h1000_0000 + 32'(i);
         m_mem[i] = 32'h1000_0000 + 32'(i);
      end
      mem[4]   = 32'hDEADBEEF;
      m_mem[4] = 32'hDEADBEEF;
      rst = 1'b1;
      set_cpu(0, 0, 0, 0);
      set_dbg(0, 0, 0, 0, 0);
      step(1);
      step(1);

      // CPU-only load
      set_cpu(1, 0, 32'h10, 0);
      step(0);
      check("cpu_only_rdata", cpu_rdata, 32'hDEADBEEF);
      set_cpu(0, 0, 0, 0);
      step(0);
      check("cpu_only_rvalid_drop", {31'd0, cpu_rvalid}, 32'd0);

      // Contention: reset first so the perf counters start from zero
      step(1);
      set_cpu(1, 0, 32'h40, 0);
      set_dbg(1, 0, 32'h44, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(0);
      end
`ifdef DM_ARB_PERF_EN
      check("perf_conflict_6", perf_conflict, 32'd6);
      check("perf_force_1", perf_force, 32'd1);
`endif
      set_cpu(0, 0, 0, 0);
      set_dbg(0, 0, 0, 0, 0);
      step(0);

      // Lock and burst write, with the CPU stalled
      set_dbg(0, 0, 0, 0, 1);
      step(0);
      set_cpu(1, 0, 32'h8, 0);
      for (int i = 0; i < 3; i++) begin
         set_dbg(1, 1, 32'(i * 4), 32'(i + 1), 1);
         step(0);
      end
      set_dbg(0, 0, 0, 0, 0);
      step(0);
      step(0);
      check("lock_mem0", mem[0], 32'd1);
      check("lock_mem2", mem[2], 32'd3);
      set_cpu(0, 0, 0, 0);

      // Debug write then CPU readback
      set_dbg(1, 1, 32'h20, 32'h12345678, 0);
      step(0);
      set_dbg(0, 0, 0, 0, 0);
      set_cpu(1, 0, 32'h20, 0);
      step(0);
      check("readback", cpu_rdata, 32'h12345678);
      set_cpu(0, 0, 0, 0);

      // Reset right after a read grant, and reset while locked
      set_dbg(1, 0, 32'h24, 0, 0);
      step(0);
      step(1);
      set_dbg(0, 0, 0, 0, 1);
      step(0);
      step(0);
      step(1);
      set_dbg(0, 0, 0, 0, 0);
      step(0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         bit lk;
         lk = dbg_lock;
         if ($urandom_range(0, 9) == 0) lk = !lk;
         set_cpu($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 255)) << 2, $urandom);
         set_dbg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 255)) << 2, $urandom, lk);
         step($urandom_range(0, 49) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
